tx_frame_sched: RTL and testbench

Frame scheduler between the TX byte buffer and the tri-mode Ethernet MAC AXI-Stream TX port.
- Accepts a frame length descriptor.
- Issues byte reads to the buffer, absorbing its 1-cycle registered read latency.
- Zero-pads runts to minimum length, marks tlast, and enforces an inter-frame idle gap before the next frame.

---
 rtl/tx_sched_pkg.sv | 29 ++
 rtl/tx_frame_sched_if.sv | 15 +
 rtl/tx_skid_buf.sv | 54 +++++
 rtl/tx_frame_sched.sv | 142 ++++++++++++++
 tb/tb_tx_frame_sched.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared types and defaults for the TX frame scheduler.
//   sched_state_t  - scheduler FSM states
//   skid_ent_t     - one skid-buffer entry {tlast tag, byte}
//   MIN_LEN_DEF    - default minimum emitted frame length (bytes, FCS excluded)
//   IFG_CYCLES_DEF - default idle gap after the tlast handshake
package tx_sched_pkg;

  localparam int MIN_LEN_DEF    = 60;
  localparam int IFG_CYCLES_DEF = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PAD,
    S_DRAIN,
    S_IFG
  } sched_state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } skid_ent_t;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tx_frame_sched_if.sv
// tx_frame_sched_if: byte-wide AXI-Stream link from the scheduler to the MAC.
//   tdata  - byte to MAC
//   tvalid - byte valid
//   tlast  - last byte of frame
//   tready - MAC ready
// master = scheduler side, slave = MAC side.
interface tx_frame_sched_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/tx_skid_buf.sv
// tx_skid_buf: 2-entry FIFO of {tlast, data} feeding the AXI-Stream output.
//   clk, rst  - clock, synchronous active-high reset (flushes contents)
//   i_push    - write i_ent this cycle
//   i_ent     - entry to write
//   i_ready   - downstream ready
//   o_valid   - head entry valid (registered, independent of i_ready)
//   o_head    - head entry (zero when empty)
//   o_occ     - current occupancy 0..2
//   o_pop     - head consumed this cycle (o_valid & i_ready)
module tx_skid_buf
  import tx_sched_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  skid_ent_t i_ent,
  input  logic      i_ready,
  output logic      o_valid,
  output skid_ent_t o_head,
  output logic [1:0] o_occ,
  output logic      o_pop
);

  skid_ent_t [1:0] r_mem;
  logic            r_wp;
  logic            r_rp;
  logic [1:0]      r_occ;
  logic            w_push;

  assign o_valid = (r_occ != 2'd0);
  assign o_pop   = o_valid & i_ready;
  assign o_head  = o_valid ? r_mem[r_rp] : '0;
  assign o_occ   = r_occ;
  // Upstream credit keeps this from ever overflowing; the guard only keeps
  // the pointers coherent if that contract is broken.
  assign w_push  = i_push & ((r_occ != 2'd2) | o_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '0;
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_occ <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_ent;
        r_wp        <= ~r_wp;
      end
      if (o_pop) r_rp <= ~r_rp;
      r_occ <= 2'(r_occ + {1'b0, w_push} - {1'b0, o_pop});
    end
  end

endmodule

// File: rtl/tx_frame_sched.sv
// tx_frame_sched: schedules one frame at a time from the TX byte buffer to the
// MAC AXI-Stream TX port, zero-padding runts and enforcing an idle gap.
//   clk, rst             - clock, synchronous active-high reset
//   desc_valid/ready     - frame length descriptor handshake
//   desc_len             - payload bytes held in the buffer for this frame
//   btx_empty, btx_data  - buffer empty flag, read data (1 cycle after read)
//   btx_rd_en            - buffer read strobe
//   m_axis               - AXI-Stream master to MAC (tdata/tvalid/tlast/tready)
//   busy                 - not IDLE
//   stall                - buffer underrun while bytes still to fetch
//   len_err              - pulse after a zero-length descriptor is dropped
module tx_frame_sched
  import tx_sched_pkg::*;
#(
  parameter  int SIZE       = 2048,
  parameter  int MIN_LEN    = MIN_LEN_DEF,
  parameter  int IFG_CYCLES = IFG_CYCLES_DEF,
  localparam int LW         = $clog2(SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                desc_valid,
  input  logic [LW-1:0]       desc_len,
  output logic                desc_ready,
  input  logic                btx_empty,
  input  logic [7:0]          btx_data,
  output logic                btx_rd_en,
  tx_frame_sched_if.master    m_axis,
  output logic                busy,
  output logic                stall,
  output logic                len_err
);

  localparam int              CW       = LW + 1;
  localparam int              IW       = cnt_w(IFG_CYCLES);
  localparam logic [CW-1:0]   MIN_L    = CW'(MIN_LEN);
  localparam logic [IW-1:0]   IFG_LOAD = (IFG_CYCLES > 0) ? IW'(IFG_CYCLES - 1) : '0;

  sched_state_t  r_state, w_state_nxt;
  logic [CW-1:0] r_rd_rem;      // buffer reads still to issue
  logic [CW-1:0] r_tot_rem;     // skid pushes (data + pad) still to make
  logic          r_pad;         // frame needs zero padding after the data
  logic [IW-1:0] r_ifg_cnt;
  logic          r_inflight;    // read issued last cycle, data on btx_data now
  logic          r_len_err;

  logic          w_accept;
  logic [CW-1:0] w_dlen;
  logic [CW-1:0] w_tot_init;
  logic          w_credit_ok;
  logic          w_rd_en;
  logic          w_pad_push;
  logic          w_push;
  logic          w_last_hs;
  skid_ent_t     w_ent;
  logic          w_sk_valid;
  skid_ent_t     w_head;
  logic [1:0]    w_occ;
  logic          w_pop;

  assign w_accept   = desc_valid & (r_state == S_IDLE);
  assign w_dlen     = {1'b0, desc_len};
  assign w_tot_init = (w_dlen < MIN_L) ? MIN_L : w_dlen;

  // Count bytes already owed to the skid (held + in flight) after this
  // cycle's pop; a new push source may start only while that stays below 2.
  // Steady state with tready=1 is occ=1, inflight=1, pop=1 -> 1 byte/cycle.
  assign w_credit_ok = (({1'b0, w_occ} + 3'(r_inflight) - 3'(w_pop)) < 3'd2);

  assign w_rd_en    = (r_state == S_FETCH) & (r_rd_rem != '0) & ~btx_empty & w_credit_ok;
  // Padding waits for the last data byte to land so ordering is preserved.
  assign w_pad_push = (r_state == S_PAD) & (r_tot_rem != '0) & ~r_inflight & w_credit_ok;
  assign w_push     = r_inflight | w_pad_push;

  assign w_ent.data = r_inflight ? btx_data : 8'h00;
  assign w_ent.last = (r_tot_rem == CW'(1));

  assign w_last_hs  = w_pop & w_head.last;

  tx_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_ent   (w_ent),
    .i_ready (m_axis.tready),
    .o_valid (w_sk_valid),
    .o_head  (w_head),
    .o_occ   (w_occ),
    .o_pop   (w_pop)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (desc_len != '0)) w_state_nxt = S_FETCH;
      S_FETCH: if (w_rd_en && (r_rd_rem == CW'(1)))
                 w_state_nxt = r_pad ? S_PAD : S_DRAIN;
      S_PAD:   if (w_pad_push && (r_tot_rem == CW'(1))) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_hs) w_state_nxt = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;
      S_IFG:   if (r_ifg_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rd_rem   <= '0;
      r_tot_rem  <= '0;
      r_pad      <= 1'b0;
      r_ifg_cnt  <= '0;
      r_inflight <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd_en;
      r_len_err  <= w_accept & (desc_len == '0);
      if (w_accept) begin
        r_rd_rem  <= w_dlen;
        r_tot_rem <= w_tot_init;
        r_pad     <= (w_tot_init > w_dlen);
      end else begin
        if (w_rd_en) r_rd_rem  <= r_rd_rem - CW'(1);
        if (w_push)  r_tot_rem <= r_tot_rem - CW'(1);
      end
      if ((r_state == S_DRAIN) && w_last_hs)
        r_ifg_cnt <= IFG_LOAD;
      else if ((r_state == S_IFG) && (r_ifg_cnt != '0))
        r_ifg_cnt <= r_ifg_cnt - IW'(1);
    end
  end

  assign desc_ready    = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign stall         = (r_state == S_FETCH) & (r_rd_rem != '0) & btx_empty;
  assign len_err       = r_len_err;
  assign btx_rd_en     = w_rd_en;
  assign m_axis.tvalid = w_sk_valid;
  assign m_axis.tdata  = w_head.data;
  assign m_axis.tlast  = w_head.last;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Scoreboard bench: stimulus pushes the expected byte stream (payload then
// zero pad, tlast on the final byte) into exp_q; a monitor pops and compares
// on every AXI-Stream handshake and also models the registered TX buffer.
module tb_tx_frame_sched;

  localparam int MIN_LEN = 60;
  localparam int IFG     = 12;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        desc_valid;
  logic [10:0] desc_len;
  logic        desc_ready;
  logic        btx_empty;
  logic [7:0]  btx_data;
  logic        btx_rd_en;
  logic        busy, stall, len_err;

  tx_frame_sched_if m_axis ();

  tx_frame_sched #(.SIZE(2048), .MIN_LEN(MIN_LEN), .IFG_CYCLES(IFG)) dut (
    .clk        (clk),
    .rst        (rst),
    .desc_valid (desc_valid),
    .desc_len   (desc_len),
    .desc_ready (desc_ready),
    .btx_empty  (btx_empty),
    .btx_data   (btx_data),
    .btx_rd_en  (btx_rd_en),
    .m_axis     (m_axis),
    .busy       (busy),
    .stall      (stall),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] buf_q [$];
  logic [7:0] pend_q [$];
  exp_t       exp_q [$];

  bit tr_rand = 1'b0;
  bit sb_off  = 1'b0;
  int rd_cnt  = 0;
  int lerr_cnt = 0;
  int last_beats = 0;
  int last_span  = 0;

  function automatic void chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Monitor + buffer model. Sample at negedge, update buffer side after posedge.
  initial begin
    bit         s_rd;
    bit         prev_tv, prev_tr, prev_l;
    logic [7:0] prev_d;
    int         beat, first_cyc, cyc, gap;
    bit         gap_on;
    exp_t       e;
    prev_tv = 0; prev_tr = 0; prev_l = 0; prev_d = 0;
    beat = 0; first_cyc = 0; cyc = 0; gap = 0; gap_on = 0;
    btx_empty = 1'b1;
    btx_data  = 8'h00;
    m_axis.tready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst || sb_off) begin
        prev_tv = 0; beat = 0; gap_on = 0;
      end else begin
        if (btx_rd_en) begin
          rd_cnt++;
          chk("rd_while_empty", int'(btx_empty), 0);
        end
        if (len_err) lerr_cnt++;
        if (prev_tv && !prev_tr) begin
          chk("hold_tvalid", int'(m_axis.tvalid), 1);
          chk("hold_tdata", int'(m_axis.tdata), int'(prev_d));
          chk("hold_tlast", int'(m_axis.tlast), int'(prev_l));
        end
        if (gap_on) begin
          if (desc_ready) begin
            chk("ifg_gap", gap, IFG);
            gap_on = 0;
          end else gap++;
        end
        if (m_axis.tvalid && m_axis.tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("tdata", int'(m_axis.tdata), int'(e.d));
            chk("tlast", int'(m_axis.tlast), int'(e.l));
          end
          if (beat == 0) first_cyc = cyc;
          beat++;
          if (m_axis.tlast) begin
            last_beats = beat;
            last_span  = cyc - first_cyc;
            beat   = 0;
            gap_on = 1;
            gap    = 0;
          end
        end
        prev_tv = m_axis.tvalid; prev_tr = m_axis.tready;
        prev_d  = m_axis.tdata;  prev_l  = m_axis.tlast;
      end
      s_rd = btx_rd_en;
      @(posedge clk);
      #1;
      if (s_rd && buf_q.size() > 0) btx_data = buf_q.pop_front();
      btx_empty = (buf_q.size() == 0);
      m_axis.tready = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Reference: payload bytes, then zeros up to MIN_LEN; tlast on the final byte.
  task automatic gen_frame(input int len, input int nfill);
    int   tot;
    exp_t e;
    logic [7:0] b;
    tot = (len == 0) ? 0 : ((len < MIN_LEN) ? MIN_LEN : len);
    for (int i = 0; i < tot; i++) begin
      if (i < len) begin
        b = 8'($urandom);
        if (i < nfill) buf_q.push_back(b);
        else           pend_q.push_back(b);
      end else b = 8'h00;
      e.d = b;
      e.l = (i == tot - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_desc(input int len);
    bit ok;
    ok = 0;
    @(posedge clk); #2;
    desc_valid = 1'b1;
    desc_len   = 11'(len);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (desc_ready) begin ok = 1; break; end
    end
    chk("desc_accept", int'(ok), 1);
    @(posedge clk); #2;
    desc_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    chk(name, int'(ok), 1);
  endtask

  task automatic run_frame(input string name, input int len);
    int r0;
    r0 = rd_cnt;
    gen_frame(len, len);
    send_desc(len);
    wait_done(name);
    chk({name, "_reads"}, rd_cnt - r0, len);
    chk({name, "_beats"}, last_beats, (len < MIN_LEN) ? MIN_LEN : len);
  endtask

  initial begin
    int r0, l0, s, r, bz;
    bit ok;
    rst = 1'b1; desc_valid = 1'b0; desc_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_desc_ready", int'(desc_ready), 1);
    chk("rst_tvalid", int'(m_axis.tvalid), 0);
    chk("rst_tlast", int'(m_axis.tlast), 0);
    chk("rst_tdata", int'(m_axis.tdata), 0);
    chk("rst_rd_en", int'(btx_rd_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_len_err", int'(len_err), 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Prefilled 100-byte frame, tready=1: back-to-back beats.
    run_frame("f100", 100);
    chk("f100_span", last_span, 99);

    // Runt: 10 data + 50 pad.
    run_frame("f10", 10);

    // Random backpressure.
    tr_rand = 1'b1;
    run_frame("f64", 64);
    tr_rand = 1'b0;

    // Underrun after 5 bytes for 30 cycles.
    r0 = rd_cnt;
    gen_frame(20, 5);
    send_desc(20);
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (buf_q.size() == 0) begin ok = 1; break; end
    end
    chk("uf_first5", int'(ok), 1);
    @(negedge clk);
    s = 0; r = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (stall) s++;
      if (btx_rd_en) r++;
    end
    chk("uf_stall_cycles", s, 30);
    chk("uf_no_reads", r, 0);
    @(posedge clk); #2;
    while (pend_q.size() > 0) buf_q.push_back(pend_q.pop_front());
    wait_done("uf_done");
    chk("uf_reads", rd_cnt - r0, 20);
    chk("uf_beats", last_beats, MIN_LEN);

    // Zero-length descriptor.
    r0 = rd_cnt; l0 = lerr_cnt;
    send_desc(0);
    bz = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy) bz++;
    end
    chk("len0_err_pulse", lerr_cnt - l0, 1);
    chk("len0_reads", rd_cnt - r0, 0);
    chk("len0_busy", bz, 0);
    run_frame("f60", 60);

    // Reset mid-FETCH of a 200-byte frame.
    gen_frame(200, 200);
    send_desc(200);
    repeat (40) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1; sb_off = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    buf_q.delete(); exp_q.delete();
    @(negedge clk);
    chk("abort_tvalid", int'(m_axis.tvalid), 0);
    chk("abort_rd_en", int'(btx_rd_en), 0);
    chk("abort_desc_ready", int'(desc_ready), 1);
    chk("abort_busy", int'(busy), 0);
    sb_off = 1'b0;
    run_frame("post_rst", 30);

    // Randomized frames.
    for (int i = 0; i < 6; i++) begin
      tr_rand = 1'($urandom_range(0, 1));
      run_frame("rand", int'($urandom_range(1, 150)));
    end
    tr_rand = 1'b0;

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
